// File: rtl/cpu_step_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU: owns the PC and steps each
// instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with run/step/halt control.
module cpu_step_sequencer #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_en,
  output logic             reg_we,
  output logic             instr_done,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [3:0] OP_LD   = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t state_q;
  state_t state_d;
  state_t ret_state;
  logic   is_alu;
  logic   is_ld;
  logic   is_st;
  logic   is_beq;
  logic   is_halt;
  logic   br_take;

  assign is_alu    = (opcode[3:2] == 2'b00);
  assign is_ld     = (opcode == OP_LD);
  assign is_st     = (opcode == OP_ST);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_halt   = (opcode == OP_HALT);
  assign ret_state = run ? S_FETCH : S_IDLE;
  assign state     = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_alu || is_beq)     state_d = S_EXECUTE;
        else if (is_ld || is_st)  state_d = S_MEM;
        else if (is_halt)         state_d = S_HALT;
        else                      state_d = ret_state;
      end
      S_EXECUTE: begin
        state_d = is_beq ? ret_state : S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_ack) state_d = is_st ? ret_state : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_d = ret_state;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decoded from state and opcode
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    br_take    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_DECODE: begin
        instr_done = !(is_alu || is_beq || is_ld || is_st);
      end
      S_EXECUTE: begin
        if (is_beq) begin
          instr_done = 1'b1;
          br_take    = zero_flag;
        end else begin
          alu_en = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = is_st;
        instr_done = is_st && dmem_ack;
      end
      S_WRITEBACK: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  // Program counter: sequential fetch, overridden by a taken branch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (ir_load) begin
      pc <= pc + PC_W'(1);
    end else if (br_take) begin
      pc <= branch_target;
    end
  end

  // Retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (instr_done) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed self-checking bench for cpu_step_sequencer: one task per scenario,
// outputs sampled on the falling clock edge.
module tb_cpu_step_sequencer;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             run;
  logic             step;
  logic [3:0]       opcode;
  logic             zero_flag;
  logic [PC_W-1:0]  branch_target;
  logic             imem_ack;
  logic             dmem_ack;
  logic [PC_W-1:0]  pc;
  logic             imem_req;
  logic             ir_load;
  logic             dmem_req;
  logic             dmem_we;
  logic             alu_en;
  logic             reg_we;
  logic             instr_done;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;

  cpu_step_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .zero_flag(zero_flag), .branch_target(branch_target),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .pc(pc), .imem_req(imem_req),
    .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_en(alu_en),
    .reg_we(reg_we), .instr_done(instr_done), .halted(halted), .state(state),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'd0; zero_flag = 1'b0;
    branch_target = 8'h00; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; step = 1'b1; opcode = 4'd2; zero_flag = 1'b1;
    branch_target = 8'h55; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++;
    if ({imem_req, ir_load, dmem_req, dmem_we, alu_en, reg_we, instr_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {imem_req, ir_load, dmem_req, dmem_we, alu_en, reg_we, instr_done});
    end
    reset = 1'b0; run = 1'b0; step = 1'b0;
  endtask

  task automatic test_alu_run();
    logic [2:0] seq [4];
    logic [7:0] exp_pc;
    seq = '{3'd1, 3'd2, 3'd3, 3'd5};
    do_reset();
    opcode = 4'b0010; imem_ack = 1'b1; dmem_ack = 1'b1; run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_pc = (i % 4 == 0) ? 8'(i / 4) : 8'(i / 4 + 1);
      checks++; if (state !== seq[i % 4]) begin errors++; $display("FAIL alu_state[%0d]: got %0d expected %0d", i, state, seq[i % 4]); end
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL alu_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
      checks++; if (reg_we !== (i % 4 == 3)) begin errors++; $display("FAIL alu_reg_we[%0d]: got %b expected %b", i, reg_we, (i % 4 == 3)); end
      checks++; if (alu_en !== (i % 4 == 2)) begin errors++; $display("FAIL alu_alu_en[%0d]: got %b expected %b", i, alu_en, (i % 4 == 2)); end
      checks++; if (retired !== 16'(i / 4)) begin errors++; $display("FAIL alu_retired[%0d]: got %0d expected %0d", i, retired, i / 4); end
    end
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL alu_stop_state: got %0d expected 0", state); end
    checks++; if (retired !== 16'd4) begin errors++; $display("FAIL alu_stop_retired: got %0d expected 4", retired); end
    checks++; if (pc !== 8'h04) begin errors++; $display("FAIL alu_stop_pc: got %h expected 04", pc); end
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL alu_stay_idle: got %0d expected 0", state); end
  endtask

  task automatic test_ld_wait();
    do_reset();
    opcode = 4'b0100; imem_ack = 1'b1; dmem_ack = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL ld_fetch: got %0d expected 1", state); end
    @(negedge clk);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL ld_decode: got %0d expected 2", state); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL ld_mem_state[%0d]: got %0d expected 4", j, state); end
      checks++; if ({dmem_req, dmem_we} !== 2'b10) begin errors++; $display("FAIL ld_mem_req[%0d]: got %b expected 10", j, {dmem_req, dmem_we}); end
      checks++; if ({reg_we, instr_done} !== 2'b00) begin errors++; $display("FAIL ld_mem_quiet[%0d]: got %b expected 00", j, {reg_we, instr_done}); end
      if (j == 3) dmem_ack = 1'b1;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL ld_wb_state: got %0d expected 5", state); end
    checks++; if ({reg_we, instr_done, dmem_req} !== 3'b110) begin errors++; $display("FAIL ld_wb_strobes: got %b expected 110", {reg_we, instr_done, dmem_req}); end
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL ld_end_state: got %0d expected 0", state); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL ld_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_step_st();
    int done_cnt;
    done_cnt = 0;
    do_reset();
    opcode = 4'b0101; imem_ack = 1'b1; dmem_ack = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    if (instr_done) done_cnt++;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL st_fetch: got %0d expected 1", state); end
    @(negedge clk);
    if (instr_done) done_cnt++;
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL st_decode: got %0d expected 2", state); end
    @(negedge clk);
    if (instr_done) done_cnt++;
    checks++; if ({state, dmem_req, dmem_we} !== {3'd4, 2'b11}) begin errors++; $display("FAIL st_mem: got state %0d req/we %b%b expected 4 11", state, dmem_req, dmem_we); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (instr_done) done_cnt++;
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL st_idle[%0d]: got %0d expected 0", k, state); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL st_done_count: got %0d expected 1", done_cnt); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL st_retired: got %0d expected 1", retired); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL st_pc: got %h expected 01", pc); end
  endtask

  task automatic test_step_held();
    do_reset();
    opcode = 4'b0111; imem_ack = 1'b1; step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({state, instr_done} !== {3'd2, 1'b1}) begin errors++; $display("FAIL held_nop_decode: got state %0d done %b expected 2 1", state, instr_done); end
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_idle_visit: got %0d expected 0", state); end
    @(negedge clk);
    step = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL held_refetch: got %0d expected 1", state); end
    repeat (2) @(negedge clk);
    checks++; if ({state, retired} !== {3'd0, 16'd2}) begin errors++; $display("FAIL held_end: got state %0d retired %0d expected 0 2", state, retired); end
  endtask

  task automatic test_beq();
    do_reset();
    opcode = 4'b0111; imem_ack = 1'b1; run = 1'b1;
    repeat (11) @(negedge clk);
    checks++; if ({state, pc} !== {3'd1, 8'h05}) begin errors++; $display("FAIL beq_setup: got state %0d pc %h expected 1 05", state, pc); end
    opcode = 4'b0110; zero_flag = 1'b0; branch_target = 8'h20;
    repeat (2) @(negedge clk);
    checks++; if ({state, instr_done, alu_en} !== {3'd3, 2'b10}) begin errors++; $display("FAIL beq_exec: got state %0d done/alu %b%b expected 3 10", state, instr_done, alu_en); end
    @(negedge clk);
    checks++; if ({imem_req, pc} !== {1'b1, 8'h06}) begin errors++; $display("FAIL beq_not_taken: got req %b pc %h expected 1 06", imem_req, pc); end
    zero_flag = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({imem_req, pc} !== {1'b1, 8'h20}) begin errors++; $display("FAIL beq_taken: got req %b pc %h expected 1 20", imem_req, pc); end
    checks++; if (retired !== 16'd7) begin errors++; $display("FAIL beq_retired: got %0d expected 7", retired); end
    run = 1'b0; opcode = 4'b0111; zero_flag = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    opcode = 4'b0110; zero_flag = 1'b1; branch_target = 8'hFF; imem_ack = 1'b1; run = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({state, pc} !== {3'd1, 8'hFF}) begin errors++; $display("FAIL wrap_fetch_ff: got state %0d pc %h expected 1 ff", state, pc); end
    opcode = 4'b0111; zero_flag = 1'b0;
    @(negedge clk);
    run = 1'b0;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", pc); end
    @(negedge clk);
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 4'b1111; imem_ack = 1'b1; dmem_ack = 1'b1; run = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b expected 1", instr_done); end
    @(negedge clk);
    checks++; if ({state, halted} !== {3'd6, 1'b1}) begin errors++; $display("FAIL halt_enter: got state %0d halted %b expected 6 1", state, halted); end
    for (int i = 0; i < 6; i++) begin
      run = (i % 2 == 0); step = (i % 2 != 0); opcode = 4'(i);
      @(negedge clk);
      checks++; if ({imem_req, dmem_req, instr_done} !== 3'b000) begin errors++; $display("FAIL halt_no_req[%0d]: got %b expected 000", i, {imem_req, dmem_req, instr_done}); end
      checks++; if ({state, pc, retired} !== {3'd6, 8'h01, 16'd1}) begin errors++; $display("FAIL halt_frozen[%0d]: got state %0d pc %h retired %0d expected 6 01 1", i, state, pc, retired); end
    end
    run = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 4'b0111; imem_ack = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    opcode = 4'b0100; dmem_ack = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({state, dmem_req, pc, retired} !== {3'd4, 1'b1, 8'h02, 16'd1}) begin errors++; $display("FAIL rmid_pre: got state %0d req %b pc %h retired %0d expected 4 1 02 1", state, dmem_req, pc, retired); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({dmem_req, imem_req, reg_we} !== 3'b000) begin errors++; $display("FAIL rmid_req_drop: got %b expected 000", {dmem_req, imem_req, reg_we}); end
    checks++; if ({state, pc, retired} !== {3'd0, 8'h00, 16'd0}) begin errors++; $display("FAIL rmid_state: got state %0d pc %h retired %0d expected 0 00 0", state, pc, retired); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rmid_after: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_alu_run();
    test_ld_wait();
    test_step_st();
    test_step_held();
    test_beq();
    test_pc_wrap();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
